// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the program counter, fetches one word per
// instruction over a ready-qualified memory request, holds it for the
// control unit and steps the PC once downstream accepts it.
// Three states: BOOT (one idle cycle after reset), FETCH (request
// outstanding) and ISSUE (instruction held until accepted).
module instr_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic [5:0]        opcode,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              jump,
  input  logic              branch_taken,
  input  logic [31:0]       branch_offset,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [31:0]       fetch_count
);

  // The PC is always word aligned, so the low two bits of the reset
  // address are dropped regardless of what the parameter holds.
  localparam logic [ADDR_W-1:0] RESET_PC_ALIGNED = {RESET_PC[ADDR_W-1:2], 2'b00};

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } state_t;

  state_t            state_reg;
  state_t            state_next;
  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] pc_next;
  logic [31:0]       instr_reg;
  logic [31:0]       instr_next;
  logic [31:0]       count_reg;
  logic [31:0]       count_next;

  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] branch_pc;
  logic [ADDR_W-1:0] jump_pc;
  logic [ADDR_W-1:0] target_pc;

  // Next-PC candidates, all derived from the held PC and instruction.
  // Adds wrap naturally modulo 2^ADDR_W; the branch offset is a word
  // offset, so it is scaled by four, which keeps the low bits zero.
  always_comb begin
    seq_pc    = pc_reg + ADDR_W'(4);
    branch_pc = seq_pc + ADDR_W'({branch_offset, 2'b00});
    jump_pc   = {seq_pc[ADDR_W-1:28], instr_reg[25:0], 2'b00};
  end

  // Redirect priority: jump wins over a taken branch, which wins over
  // falling through. Only consumed in the ISSUE handshake cycle.
  always_comb begin
    target_pc = seq_pc;
    if (jump) begin
      target_pc = jump_pc;
    end else if (branch_taken) begin
      target_pc = branch_pc;
    end
  end

  // State register plus the PC, held instruction and accept counter.
  // Reset is asynchronous so an outstanding fetch is abandoned at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= BOOT;
      pc_reg    <= RESET_PC_ALIGNED;
      instr_reg <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      instr_reg <= instr_next;
      count_reg <= count_next;
    end
  end

  // Next-state logic and Moore outputs. imem_ready is looked at only in
  // FETCH, so a late response after reset or during ISSUE is dropped.
  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    instr_next  = instr_reg;
    count_next  = count_reg;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state_reg)
      BOOT: begin
        state_next = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          instr_next = imem_rdata;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        instr_valid = 1'b1;
        if (instr_ready) begin
          count_next = count_reg + 32'd1;
          pc_next    = target_pc;
          state_next = FETCH;
        end
      end
      default: begin
        state_next = BOOT;
      end
    endcase
  end

  // Output view of the held state. The opcode is zeroed while nothing
  // valid is held; consumers still gate side effects with instr_valid,
  // since an all-zero opcode decodes as an R-type instruction.
  always_comb begin
    imem_addr   = pc_reg;
    pc          = pc_reg;
    pc_plus4    = seq_pc;
    instr       = instr_reg;
    fetch_count = count_reg;
    opcode      = instr_valid ? instr_reg[31:26] : 6'b000000;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: reset/boot, zero-wait sequential
// fetch, branches, jump priority, memory and downstream stalls, async
// reset mid-fetch and PC wrap-around.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic        instr_valid;
  logic        instr_ready;
  logic        jump;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] fetch_count;

  int n_cmp;
  int n_err;

  instr_fetch_unit #(
    .ADDR_W   (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .instr         (instr),
    .opcode        (opcode),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .jump          (jump),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .fetch_count   (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starting at a negedge in FETCH: return rdata with zero wait, then
  // accept it with the given redirect inputs and check the new fetch PC.
  task automatic fetch_issue(input string tag, input logic [31:0] rdata,
                             input logic jmp, input logic br,
                             input logic [31:0] off, input logic [31:0] exp_pc);
    imem_ready = 1'b1;
    imem_rdata = rdata;
    @(negedge clk);
    check({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
    imem_ready    = 1'b0;
    instr_ready   = 1'b1;
    jump          = jmp;
    branch_taken  = br;
    branch_offset = off;
    @(negedge clk);
    instr_ready   = 1'b0;
    jump          = 1'b0;
    branch_taken  = 1'b0;
    branch_offset = $urandom;
    check({tag, "_pc"}, pc, exp_pc);
    check({tag, "_addr"}, imem_addr, exp_pc);
    check({tag, "_req"}, {31'd0, imem_req}, 32'd1);
    $display("xfer %-10s instr=%h jump=%0d br=%0d off=%h -> pc=%h count=%0d",
             tag, rdata, jmp, br, off, pc, fetch_count);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    imem_ready = 1'b0;
    imem_rdata = '0;
    instr_ready = 1'b0;
    jump = 1'b0;
    branch_taken = 1'b0;
    branch_offset = '0;

    // Reset held for three cycles, with a stray imem_ready in the middle.
    for (int i = 0; i < 3; i++) begin
      imem_ready = (i == 1);
      imem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      check("rst_req", {31'd0, imem_req}, 32'd0);
      check("rst_valid", {31'd0, instr_valid}, 32'd0);
      check("rst_count", fetch_count, 32'd0);
    end
    check("rst_pc", pc, 32'h0);
    check("rst_pc4", pc_plus4, 32'h4);
    check("rst_instr", instr, 32'h0);
    check("rst_opcode", {26'd0, opcode}, 32'h0);

    // Release: one idle BOOT cycle, then the request appears.
    imem_ready = 1'b0;
    rst_n = 1'b1;
    #1;
    check("boot_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    check("first_req", {31'd0, imem_req}, 32'd1);
    check("first_addr", imem_addr, 32'h0);
    check("first_valid", {31'd0, instr_valid}, 32'd0);

    // Zero-wait sequential fetch: valid every other cycle.
    imem_ready  = 1'b1;
    imem_rdata  = 32'h8C01_0000;
    instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("seq_valid", {31'd0, instr_valid}, 32'd1);
      check("seq_pc", pc, 32'(i * 4));
      check("seq_opcode", {26'd0, opcode}, 32'h23);
      check("seq_instr", instr, 32'h8C01_0000);
      @(negedge clk);
      check("seq_gap_valid", {31'd0, instr_valid}, 32'd0);
      check("seq_gap_opcode", {26'd0, opcode}, 32'h0);
      check("seq_count", fetch_count, 32'(i + 1));
      $display("xfer seq        pc=%h count=%0d", pc, fetch_count);
    end
    imem_ready  = 1'b0;
    instr_ready = 1'b0;
    check("seq_pc_c", pc, 32'hC);

    // Branches and jumps.
    fetch_issue("to_10",    32'h0000_0000, 1'b0, 1'b0, 32'h0,         32'h10);
    fetch_issue("br_fwd",   32'h1000_0003, 1'b0, 1'b1, 32'h3,         32'h20);
    fetch_issue("br_back",  32'h1000_FFFB, 1'b0, 1'b1, 32'hFFFF_FFFB, 32'h10);
    fetch_issue("br_self",  32'h1000_FFFF, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h10);
    fetch_issue("jmp",      32'h0810_0000, 1'b1, 1'b0, 32'h0,         32'h0040_0000);
    fetch_issue("jmp_prio", 32'h0810_0004, 1'b1, 1'b1, 32'h3,         32'h0040_0010);
    check("count_9", fetch_count, 32'd9);

    // Memory stall: request and address held while imem_ready is low.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mstall_req", {31'd0, imem_req}, 32'd1);
      check("mstall_addr", imem_addr, 32'h0040_0010);
      check("mstall_valid", {31'd0, instr_valid}, 32'd0);
    end
    imem_ready = 1'b1;
    imem_rdata = 32'h1234_5678;
    @(negedge clk);
    // Downstream stall, with imem_ready/rdata wiggling outside FETCH.
    imem_rdata = 32'hCAFE_F00D;
    for (int i = 0; i < 5; i++) begin
      imem_ready = i[0];
      @(negedge clk);
      check("dstall_valid", {31'd0, instr_valid}, 32'd1);
      check("dstall_instr", instr, 32'h1234_5678);
      check("dstall_opcode", {26'd0, opcode}, 32'h04);
      check("dstall_pc", pc, 32'h0040_0010);
      check("dstall_count", fetch_count, 32'd9);
      check("dstall_req", {31'd0, imem_req}, 32'd0);
    end
    imem_ready  = 1'b0;
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    check("after_stall_count", fetch_count, 32'd10);
    check("after_stall_pc", pc, 32'h0040_0014);
    $display("xfer stall      pc=%h count=%0d", pc, fetch_count);

    // Asynchronous reset while a fetch is outstanding.
    #2;
    rst_n = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = 32'hFFFF_FFFF;
    #1;
    check("arst_pc", pc, 32'h0);
    check("arst_valid", {31'd0, instr_valid}, 32'd0);
    check("arst_req", {31'd0, imem_req}, 32'd0);
    check("arst_count", fetch_count, 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("arst_hold_valid", {31'd0, instr_valid}, 32'd0);
      check("arst_hold_instr", instr, 32'h0);
    end
    imem_ready = 1'b0;
    rst_n = 1'b1;
    #1;
    check("reboot_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    check("reboot_req2", {31'd0, imem_req}, 32'd1);
    check("reboot_addr", imem_addr, 32'h0);

    // PC wrap: branch to the top word, then fall through to zero.
    fetch_issue("seq_rst",  32'h0000_0000, 1'b0, 1'b0, 32'h0,         32'h4);
    fetch_issue("br_top",   32'h1000_0000, 1'b0, 1'b1, 32'h3FFF_FFFD, 32'hFFFF_FFFC);
    check("top_pc4", pc_plus4, 32'h0);
    fetch_issue("wrap",     32'h0000_0000, 1'b0, 1'b0, 32'h0,         32'h0);
    check("wrap_count", fetch_count, 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
